// File: rtl/microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : microwave_timer_ctrl
// Description : Microwave oven controller with a programmable, prescaled cook
//               countdown. Produces the {Start,Close,Heat,Error} status code
//               from the door / start / cancel inputs and counts the cook time
//               down in seconds of TICK_DIV clock cycles each.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: define DOOR_PAUSE_EN to pause (rather than abort) a cook when
//               the door opens; paused is tied low when it is not defined.
// Parameters  : TIME_W   - width of cook_time / time_left (seconds)
//               TICK_DIV - clk cycles per one-second tick (>= 1)
// Ports       : clk        in  system clock, rising edge
//               sys_reset  in  asynchronous active-high system reset
//               reset      in  user cancel, synchronous
//               closeDoor  in  1 = door closed
//               startOven  in  start request (level)
//               load_time  in  load cook_time into time_left
//               cook_time  in  requested cook time [TIME_W]
//               Start, Close, Heat, Error  out  registered status code
//               time_left  out remaining seconds [TIME_W]
//               done_pulse out one-cycle pulse on cook completion
//               paused     out 1 while the cook is paused
// ============================================================================
module microwave_timer_ctrl #(
    parameter int TIME_W   = 8,
    parameter int TICK_DIV = 100
) (
    input  logic              clk,
    input  logic              sys_reset,
    input  logic              reset,
    input  logic              closeDoor,
    input  logic              startOven,
    input  logic              load_time,
    input  logic [TIME_W-1:0] cook_time,
    output logic              Start,
    output logic              Close,
    output logic              Heat,
    output logic              Error,
    output logic [TIME_W-1:0] time_left,
    output logic              done_pulse,
    output logic              paused
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] C_PS_MAX = PS_W'(TICK_DIV - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] S_ERR    = 4'd1;
    localparam logic [3:0] S_ERR_C  = 4'd2;
    localparam logic [3:0] CLOSED   = 4'd3;
    localparam logic [3:0] ZERO_ERR = 4'd4;
    localparam logic [3:0] START    = 4'd5;
    localparam logic [3:0] WARM     = 4'd6;
    localparam logic [3:0] COOK     = 4'd7;
    localparam logic [3:0] PAUSED   = 4'd8;

    logic [3:0]        state_q,  state_d;
    logic [TIME_W-1:0] time_q,   time_d;
    logic [PS_W-1:0]   ps_q,     ps_d;
    logic              done_q,   done_d;
    logic [3:0]        status_q, status_d;
    logic              tick_w;

    assign tick_w = (state_q == COOK) && (ps_q == C_PS_MAX);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        ps_d    = ps_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_time)      time_d  = cook_time;
                if (closeDoor)      state_d = CLOSED;
                else if (startOven) state_d = S_ERR;
            end
            S_ERR: begin
                if (closeDoor) state_d = S_ERR_C;
            end
            S_ERR_C: begin
                if (!closeDoor) state_d = S_ERR;
                else if (reset) state_d = CLOSED;
            end
            CLOSED: begin
                if (load_time) time_d = cook_time;
                if (!closeDoor) begin
                    state_d = IDLE;
                end else if (startOven) begin
                    if (time_q != '0) begin
                        state_d = START;
                        // Fresh cook: the first second starts from zero.
                        ps_d    = '0;
                    end else begin
                        state_d = ZERO_ERR;
                    end
                end
            end
            ZERO_ERR: begin
                if (load_time) time_d = cook_time;
                if (!closeDoor)                          state_d = IDLE;
                else if (reset)                          state_d = CLOSED;
                else if (load_time && cook_time != '0)   state_d = CLOSED;
            end
            START: state_d = WARM;
            WARM:  state_d = COOK;
            COOK: begin
                // The prescaler completes its second even when a door or
                // cancel event swallows the tick, so a resumed cook restarts
                // on a second boundary.
                ps_d = tick_w ? '0 : ps_q + 1'b1;
                if (!closeDoor) begin
`ifdef DOOR_PAUSE_EN
                    state_d = PAUSED;
`else
                    state_d = IDLE;
                    time_d  = '0;
                    ps_d    = '0;
`endif
                end else if (reset) begin
                    state_d = CLOSED;
                    time_d  = '0;
                end else if (tick_w) begin
                    if (time_q <= TIME_W'(1)) begin
                        state_d = CLOSED;
                        time_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        time_d  = time_q - 1'b1;
                    end
                end
            end
`ifdef DOOR_PAUSE_EN
            PAUSED: begin
                if (reset) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (closeDoor && startOven) begin
                    // Resume keeps the held prescaler value.
                    state_d = START;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Status code is registered from the next state so it changes together
    // with the state register.
    always_comb begin
        status_d = 4'b0000;
        case (state_d)
            IDLE:     status_d = 4'b0000;
            S_ERR:    status_d = 4'b1001;
            S_ERR_C:  status_d = 4'b1101;
            CLOSED:   status_d = 4'b0100;
            ZERO_ERR: status_d = 4'b0101;
            START:    status_d = 4'b1100;
            WARM:     status_d = 4'b1110;
            COOK:     status_d = 4'b0110;
            PAUSED:   status_d = 4'b0000;
            default:  status_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q  <= IDLE;
            time_q   <= '0;
            ps_q     <= '0;
            done_q   <= 1'b0;
            status_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            ps_q     <= ps_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

`ifdef DOOR_PAUSE_EN
    logic paused_q;

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) paused_q <= 1'b0;
        else           paused_q <= (state_d == PAUSED);
    end

    assign paused = paused_q;
`else
    assign paused = 1'b0;
`endif

    assign {Start, Close, Heat, Error} = status_q;
    assign time_left  = time_q;
    assign done_pulse = done_q;

endmodule
`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_microwave_timer_ctrl
// Description : Scoreboard bench for microwave_timer_ctrl (TIME_W=8,
//               TICK_DIV=4). Stimulus pushes the expected outputs for the
//               next clock edge; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microwave_timer_ctrl;

    logic       clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic       reset = 1'b0;
    logic       closeDoor = 1'b0;
    logic       startOven = 1'b0;
    logic       load_time = 1'b0;
    logic [7:0] cook_time = 8'd0;
    logic       Start, Close, Heat, Error;
    logic [7:0] time_left;
    logic       done_pulse;
    logic       paused;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] st;
        logic [7:0] tl;
        logic       done;
        logic       pau;
        string      nm;
    } exp_t;

    exp_t sb[$];

    microwave_timer_ctrl #(.TIME_W(8), .TICK_DIV(4)) dut (
        .clk        (clk),
        .sys_reset  (sys_reset),
        .reset      (reset),
        .closeDoor  (closeDoor),
        .startOven  (startOven),
        .load_time  (load_time),
        .cook_time  (cook_time),
        .Start      (Start),
        .Close      (Close),
        .Heat       (Heat),
        .Error      (Error),
        .time_left  (time_left),
        .done_pulse (done_pulse),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] est, input logic [7:0] etl,
                         input logic ed, input logic ep);
        logic [3:0] got;
        got = {Start, Close, Heat, Error};
        n_checks++;
        if (got === est && time_left === etl && done_pulse === ed && paused === ep) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got status=%b time_left=%0d done=%b paused=%b, expected status=%b time_left=%0d done=%b paused=%b",
                     nm, got, time_left, done_pulse, paused, est, etl, ed, ep);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic d, input logic s, input logic r, input logic l,
                        input logic [7:0] ct, input logic [3:0] est, input logic [7:0] etl,
                        input logic ed, input logic ep, input string nm);
        exp_t e;
        @(negedge clk);
        closeDoor = d;
        startOven = s;
        reset     = r;
        load_time = l;
        cook_time = ct;
        e.st = est; e.tl = etl; e.done = ed; e.pau = ep; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid one step after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(e.nm, e.st, e.tl, e.done, e.pau);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset_state", 4'b0000, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        sys_reset = 1'b0;

        // 1: load 3, close, start, full cook
        step(0,0,0,1,8'd3, 4'b0000, 8'd3, 0,0, "t1_load_idle");
        step(1,0,0,0,8'd0, 4'b0100, 8'd3, 0,0, "t1_closed");
        step(1,1,0,0,8'd0, 4'b1100, 8'd3, 0,0, "t1_start");
        step(1,0,0,0,8'd0, 4'b1110, 8'd3, 0,0, "t1_warm");
        for (int i = 0; i < 12; i++)
            step(1,0,0,0,8'd0, 4'b0110, 8'(3 - i/4), 0,0, "t1_cook");
        step(1,0,0,0,8'd0, 4'b0100, 8'd0, 1,0, "t1_done");
        step(1,0,0,0,8'd0, 4'b0100, 8'd0, 0,0, "t1_done_clear");

        // 2: start error path, time_left kept through cancel
        step(1,0,0,1,8'd7, 4'b0100, 8'd7, 0,0, "t2_load_closed");
        step(0,0,0,0,8'd0, 4'b0000, 8'd7, 0,0, "t2_open");
        step(0,1,0,0,8'd0, 4'b1001, 8'd7, 0,0, "t2_s_err");
        step(0,0,0,1,8'd9, 4'b1001, 8'd7, 0,0, "t2_load_ignored");
        step(1,0,0,0,8'd0, 4'b1101, 8'd7, 0,0, "t2_s_err_c");
        step(0,0,0,0,8'd0, 4'b1001, 8'd7, 0,0, "t2_reopen");
        step(1,0,0,0,8'd0, 4'b1101, 8'd7, 0,0, "t2_reclose");
        step(1,0,1,0,8'd0, 4'b0100, 8'd7, 0,0, "t2_cancel");

        // 6: cancel mid-cook at time_left=4
        step(1,0,0,1,8'd5, 4'b0100, 8'd5, 0,0, "t6_load");
        step(1,1,0,0,8'd0, 4'b1100, 8'd5, 0,0, "t6_start");
        step(1,0,0,0,8'd0, 4'b1110, 8'd5, 0,0, "t6_warm");
        for (int i = 0; i < 4; i++)
            step(1,0,0,1,8'd9, 4'b0110, 8'd5, 0,0, "t6_cook");
        step(1,0,0,0,8'd0, 4'b0110, 8'd4, 0,0, "t6_cook_tl4");
        step(1,0,1,0,8'd0, 4'b0100, 8'd0, 0,0, "t6_cancel");
        step(1,0,0,0,8'd0, 4'b0100, 8'd0, 0,0, "t6_no_done");

        // 3: zero time error and recovery by load
        step(1,1,0,0,8'd0, 4'b0101, 8'd0, 0,0, "t3_zero_err");
        step(1,0,0,1,8'd0, 4'b0101, 8'd0, 0,0, "t3_load_zero");
        step(1,0,0,1,8'd5, 4'b0100, 8'd5, 0,0, "t3_load_five");

        // 4: door opens on the tick cycle at time_left=2
        step(1,0,0,1,8'd3, 4'b0100, 8'd3, 0,0, "t4_load");
        step(1,1,0,0,8'd0, 4'b1100, 8'd3, 0,0, "t4_start");
        step(1,0,0,0,8'd0, 4'b1110, 8'd3, 0,0, "t4_warm");
        for (int i = 0; i < 8; i++)
            step(1,0,0,0,8'd0, 4'b0110, 8'(3 - i/4), 0,0, "t4_cook");
`ifdef DOOR_PAUSE_EN
        step(0,0,0,0,8'd0, 4'b0000, 8'd2, 0,1, "t4_paused");
        step(1,0,0,0,8'd0, 4'b0000, 8'd2, 0,1, "t4_paused_closed");
        step(1,1,0,0,8'd0, 4'b1100, 8'd2, 0,0, "t4_resume");
        step(1,0,0,0,8'd0, 4'b1110, 8'd2, 0,0, "t4_warm2");
        for (int i = 0; i < 8; i++)
            step(1,0,0,0,8'd0, 4'b0110, 8'(2 - i/4), 0,0, "t4_cook2");
        step(1,0,0,0,8'd0, 4'b0100, 8'd0, 1,0, "t4_done");
`else
        step(0,0,0,0,8'd0, 4'b0000, 8'd0, 0,0, "t4_abort");
        step(1,0,0,0,8'd0, 4'b0100, 8'd0, 0,0, "t4_closed");
`endif
        step(1,0,0,0,8'd0, 4'b0100, 8'd0, 0,0, "t4_settle");

        // 5: asynchronous reset in the middle of a cook
        step(1,0,0,1,8'd2, 4'b0100, 8'd2, 0,0, "t5_load");
        step(1,1,0,0,8'd0, 4'b1100, 8'd2, 0,0, "t5_start");
        step(1,0,0,0,8'd0, 4'b1110, 8'd2, 0,0, "t5_warm");
        step(1,0,0,0,8'd0, 4'b0110, 8'd2, 0,0, "t5_cook");
        @(posedge clk);
        #3;
        sys_reset = 1'b1;
        #1;
        check("t5_async_reset", 4'b0000, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        sys_reset = 1'b0;
        step(0,0,0,0,8'd0, 4'b0000, 8'd0, 0,0, "t5_after_reset");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
